hazard_controller: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage CPU (IF, ID, EX, MEM, WB). It consumes the per-stage control bits produced by the opcode decoder (branch, RegWrite, MemRead) plus register addresses. It drives stall, flush and forwarding selects for every pipeline register, and freezes the pipeline during multi-cycle data-memory accesses. It also maintains a memory-timeout watchdog and saturating performance counters.

---
 rtl/hazard_controller.sv | 180 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard, freeze and forwarding control for the 5-stage pipeline.
// Also provides the memory-timeout watchdog and saturating perf counters.
module hazard_controller #(
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_memread,
    input  logic              i_ex_branch,
    input  logic              i_ex_taken,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_mem_regwrite,
    input  logic              i_wb_regwrite,
    input  logic              i_mem_req,
    input  logic              i_mem_ready,
    input  logic              i_cnt_clr,
    output logic              o_pc_stall,
    output logic              o_ifid_stall,
    output logic              o_idex_stall,
    output logic              o_exmem_stall,
    output logic              o_ifid_flush,
    output logic              o_idex_flush,
    output logic              o_memwb_flush,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_halt,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_freeze;
    logic w_branch;
    logic w_lu_match;
    logic w_halted;
    logic w_br_eff;
    logic w_lu_eff;
    logic w_stall_inc;
    logic w_flush_inc;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (i_mem_regwrite && i_mem_rd != '0 && i_mem_rd == rs)
            sel = 2'b10;
        else if (i_wb_regwrite && i_wb_rd != '0 && i_wb_rd == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign w_freeze   = i_mem_req & ~i_mem_ready;
    assign w_branch   = i_ex_branch & i_ex_taken;
    assign w_lu_match = i_ex_memread & (i_ex_rd != '0) &
                        ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                         (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
    assign w_halted   = (r_state == HALT);
    assign w_br_eff   = ~w_halted & ~w_freeze & w_branch;
    assign w_lu_eff   = ~w_halted & ~w_freeze & ~w_branch & w_lu_match;

    // Every HALT cycle counts as a stall cycle.
    assign w_stall_inc = w_halted | (~w_halted & w_freeze) | w_lu_eff;
    assign w_flush_inc = w_br_eff;

    always_comb begin
        o_pc_stall    = 1'b0;
        o_ifid_stall  = 1'b0;
        o_idex_stall  = 1'b0;
        o_exmem_stall = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_memwb_flush = 1'b0;
        o_fwd_a       = 2'b00;
        o_fwd_b       = 2'b00;
        if (i_rst_n) begin
            if (w_halted) begin
                o_pc_stall    = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_stall  = 1'b1;
                o_exmem_stall = 1'b1;
            end else begin
                o_fwd_a = fwd_sel(i_ex_rs1);
                o_fwd_b = fwd_sel(i_ex_rs2);
                if (w_freeze) begin
                    o_pc_stall    = 1'b1;
                    o_ifid_stall  = 1'b1;
                    o_idex_stall  = 1'b1;
                    o_exmem_stall = 1'b1;
                    o_memwb_flush = 1'b1;
                end else if (w_branch) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (w_lu_match) begin
                    o_pc_stall   = 1'b1;
                    o_ifid_stall = 1'b1;
                    o_idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state <= MEM_WAIT;
                        r_wait  <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!w_freeze) begin
                        r_state <= RUN;
                        r_wait  <= '0;
                    end else if (r_wait == W_LAST) begin
                        r_state <= HALT;
                        r_halt  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                HALT: begin
                    r_state <= HALT;
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                    r_wait  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_halt      = r_halt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (long/short timeout) on shared
// stimulus, checked each cycle against a rule-level model plus literals.
module tb_hazard_controller;

    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0;
    logic id_use1 = 0, id_use2 = 0;
    logic [AW-1:0] ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
    logic ex_mr = 0, ex_br = 0, ex_tk = 0;
    logic [AW-1:0] mem_rd = '0, wb_rd = '0;
    logic mem_rw = 0, wb_rw = 0;
    logic mem_req = 0, mem_rdy = 0, clr = 0;

    logic a_pc, a_ifs, a_ids, a_exs, a_iff, a_idf, a_mwf, a_halt;
    logic [1:0] a_fa, a_fb;
    logic [3:0] a_sc, a_fc;
    logic b_pc, b_ifs, b_ids, b_exs, b_iff, b_idf, b_mwf, b_halt;
    logic [1:0] b_fa, b_fb;
    logic [15:0] b_sc, b_fc;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_AW(AW), .CNT_W(4), .TIMEOUT(8)) u_a (
        .i_clk(clk), .i_rst_n(rst_a),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use1), .i_id_use_rs2(id_use2),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
        .i_ex_memread(ex_mr), .i_ex_branch(ex_br), .i_ex_taken(ex_tk),
        .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
        .i_mem_regwrite(mem_rw), .i_wb_regwrite(wb_rw),
        .i_mem_req(mem_req), .i_mem_ready(mem_rdy), .i_cnt_clr(clr),
        .o_pc_stall(a_pc), .o_ifid_stall(a_ifs), .o_idex_stall(a_ids),
        .o_exmem_stall(a_exs), .o_ifid_flush(a_iff), .o_idex_flush(a_idf),
        .o_memwb_flush(a_mwf), .o_fwd_a(a_fa), .o_fwd_b(a_fb),
        .o_halt(a_halt), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc));

    hazard_controller #(.REG_AW(AW), .CNT_W(16), .TIMEOUT(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_b),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use1), .i_id_use_rs2(id_use2),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
        .i_ex_memread(ex_mr), .i_ex_branch(ex_br), .i_ex_taken(ex_tk),
        .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
        .i_mem_regwrite(mem_rw), .i_wb_regwrite(wb_rw),
        .i_mem_req(mem_req), .i_mem_ready(mem_rdy), .i_cnt_clr(clr),
        .o_pc_stall(b_pc), .o_ifid_stall(b_ifs), .o_idex_stall(b_ids),
        .o_exmem_stall(b_exs), .o_ifid_flush(b_iff), .o_idex_flush(b_idf),
        .o_memwb_flush(b_mwf), .o_fwd_a(b_fa), .o_fwd_b(b_fb),
        .o_halt(b_halt), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc));

    typedef struct {
        bit halt;
        int run;
        int sc;
        int fc;
    } mst_t;

    mst_t ma, mb;

    function automatic bit m_frz();
        return mem_req && !mem_rdy;
    endfunction

    function automatic bit m_br();
        return ex_br && ex_tk;
    endfunction

    function automatic bit m_lu();
        bit hit1, hit2;
        hit1 = id_use1 && id_rs1 == ex_rd;
        hit2 = id_use2 && id_rs2 == ex_rd;
        return ex_mr && ex_rd != 0 && (hit1 || hit2);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
        if (mem_rw && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_rw && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {pc,ifid,idex,exmem stalls, ifid,idex,memwb flushes, fwd_a, fwd_b}
    function automatic logic [10:0] m_out(input mst_t s, input bit rst_n);
        logic [10:0] o;
        o = '0;
        if (!rst_n) return o;
        if (s.halt) return 11'b1111_000_00_00;
        o[3:0] = {m_fwd(ex_rs1), m_fwd(ex_rs2)};
        if (m_frz()) o[10:4] = 7'b1111_001;
        else if (m_br()) o[10:4] = 7'b0000_110;
        else if (m_lu()) o[10:4] = 7'b1100_010;
        return o;
    endfunction

    function automatic mst_t m_next(input mst_t s, input int to,
                                    input int cmax);
        mst_t n;
        bit si, fi;
        n = s;
        si = 0;
        fi = 0;
        if (s.halt) begin
            si = 1;
        end else begin
            if (m_frz()) begin
                n.run = s.run + 1;
                if (n.run >= to) n.halt = 1;
                si = 1;
            end else begin
                n.run = 0;
                if (m_br()) fi = 1;
                else if (m_lu()) si = 1;
            end
        end
        if (clr) begin
            n.sc = 0;
            n.fc = 0;
        end else begin
            if (si && n.sc < cmax) n.sc = n.sc + 1;
            if (fi && n.fc < cmax) n.fc = n.fc + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_a)
        if (!rst_a) ma = '{0, 0, 0, 0};
        else ma = m_next(ma, 8, 15);

    always @(posedge clk or negedge rst_b)
        if (!rst_b) mb = '{0, 0, 0, 0};
        else mb = m_next(mb, 4, 65535);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a_outs", int'({a_pc, a_ifs, a_ids, a_exs, a_iff, a_idf,
                              a_mwf, a_fa, a_fb}), int'(m_out(ma, rst_a)));
        check("a_halt", int'(a_halt), int'(ma.halt));
        check("a_scnt", int'(a_sc), ma.sc);
        check("a_fcnt", int'(a_fc), ma.fc);
        check("b_outs", int'({b_pc, b_ifs, b_ids, b_exs, b_iff, b_idf,
                              b_mwf, b_fa, b_fb}), int'(m_out(mb, rst_b)));
        check("b_halt", int'(b_halt), int'(mb.halt));
        check("b_scnt", int'(b_sc), mb.sc);
        check("b_fcnt", int'(b_fc), mb.fc);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_use1 = 0; id_use2 = 0; ex_mr = 0; ex_br = 0; ex_tk = 0;
        mem_rw = 0; wb_rw = 0; mem_req = 0; mem_rdy = 0; clr = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0;
    endtask

    task automatic clear_cnt();
        idle();
        clr = 1;
        cyc();
        clr = 0;
    endtask

    initial begin
        #2;
        check("rst_a_stall", int'({a_pc, a_ifs, a_ids, a_exs}), 0);
        check("rst_a_flush", int'({a_iff, a_idf, a_mwf}), 0);
        check("rst_a_cnt", int'(a_sc) + int'(a_fc) + int'(a_halt), 0);
        cyc();
        cyc();
        rst_a = 1;
        cyc();

        ex_mr = 1; ex_rd = 3; id_rs2 = 3; id_use2 = 1;
        #1;
        check("lu_pc", int'(a_pc), 1);
        check("lu_ifid", int'(a_ifs), 1);
        check("lu_idexf", int'(a_idf), 1);
        check("lu_idexs", int'(a_ids), 0);
        cyc();
        check("lu_scnt", int'(a_sc), 1);
        ex_rd = 0; id_rs2 = 0;
        #1;
        check("lu_rd0", int'(a_pc), 0);
        cyc();
        check("lu_rd0_cnt", int'(a_sc), 1);

        clear_cnt();
        check("clr_sc", int'(a_sc), 0);
        ex_mr = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1;
        ex_br = 1; ex_tk = 1;
        #1;
        check("br_ifidf", int'(a_iff), 1);
        check("br_idexf", int'(a_idf), 1);
        check("br_pc", int'(a_pc), 0);
        cyc();
        check("br_fcnt", int'(a_fc), 1);
        check("br_scnt", int'(a_sc), 0);
        idle();

        ex_rs1 = 5; mem_rd = 5; wb_rd = 5; mem_rw = 1; wb_rw = 1;
        #1;
        check("fwd_mem", int'(a_fa), 2);
        mem_rw = 0;
        #1;
        check("fwd_wb", int'(a_fa), 1);
        ex_rs2 = 0; wb_rd = 0; wb_rw = 1;
        #1;
        check("fwd_r0", int'(a_fb), 0);
        ex_rs2 = 6; wb_rd = 6; mem_rd = 0; mem_rw = 1;
        #1;
        check("fwd_b_wb", int'(a_fb), 1);
        cyc();
        idle();

        clear_cnt();
        mem_req = 1; mem_rdy = 1;
        #1;
        check("rdy_first", int'(a_pc), 0);
        cyc();
        mem_rdy = 0; ex_br = 1; ex_tk = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("frz_stalls", int'({a_pc, a_ifs, a_ids, a_exs}), 15);
            check("frz_mwf", int'(a_mwf), 1);
            check("frz_ifidf", int'(a_iff), 0);
            cyc();
        end
        mem_rdy = 1;
        #1;
        check("frz_end", int'(a_exs), 0);
        check("frz_br", int'(a_iff), 1);
        cyc();
        check("frz_scnt", int'(a_sc), 5);
        check("frz_fcnt", int'(a_fc), 1);
        idle();

        clear_cnt();
        ex_mr = 1; ex_rd = 2; id_rs1 = 2; id_use1 = 1;
        repeat (20) cyc();
        check("sat_scnt", int'(a_sc), 15);
        clr = 1;
        cyc();
        clr = 0;
        check("clr_stall", int'(a_sc), 0);
        idle();
        cyc();

        rst_b = 1;
        cyc();
        mem_req = 1; mem_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_nohalt", int'(b_halt), 0);
            cyc();
        end
        check("to_halt", int'(b_halt), 1);
        check("to_stalls", int'({b_pc, b_ifs, b_ids, b_exs}), 15);
        check("to_mwf", int'(b_mwf), 0);
        cyc();
        mem_rdy = 1; ex_rs1 = 4; mem_rd = 4; mem_rw = 1;
        #1;
        check("to_fwd_a", int'(a_fa), 2);
        check("to_fwd_b", int'(b_fa), 0);
        cyc();
        check("to_sticky", int'(b_halt), 1);
        check("to_scnt", int'(b_sc), 6);
        rst_b = 0;
        #1;
        check("to_rst_out", int'({b_pc, b_ifs, b_ids, b_exs, b_mwf}), 0);
        check("to_rst_halt", int'(b_halt), 0);
        check("to_rst_cnt", int'(b_sc), 0);
        idle();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
